vec_modexp_unit: RTL

// - Execute stage downstream of the vector register file.
// - Computes, per lane, R[i] = B[i]^E[i] mod N for a 6-lane x 8-bit vector.
// - B and E are taken from register file RD1/RD2; N is a shared scalar.
// - Writes the result vector back through the WE3/A3/WD3 port.
// - Uses constant-time left-to-right square-and-multiply, with interleaved shift-add modular multiply.

---
 rtl/vec_modexp_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vec_modexp_unit.sv
// Per-lane modular exponentiation R[i] = B[i]^E[i] mod N over a packed vector.
// Constant-time left-to-right square-and-multiply built on a bit-serial shift-add modmul.
module vec_modexp_unit #(
  parameter int LANES = 6,
  parameter int W     = 8,
  parameter int AW    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [AW-1:0]             dst,
  input  logic [LANES-1:0][W-1:0]   base,
  input  logic [LANES-1:0][W-1:0]   expo,
  input  logic [W-1:0]              modulus,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      we,
  output logic [AW-1:0]             wa,
  output logic [LANES-1:0][W-1:0]   wd
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {IDLE, REDUCE, SQR, MUL, WRITE} state_t;

  state_t                    state_reg, state_next;
  logic [AW-1:0]             dst_reg;
  logic [LANES-1:0][W-1:0]   base_reg, expo_reg, b_reg, r_reg, acc_reg, prod;
  logic [W-1:0]              n_reg;
  logic                      err_reg;
  logic [CW-1:0]             cnt_reg, k_reg, bidx;
  logic                      last_step;

  assign bidx      = CW'(W - 1) - cnt_reg;
  assign last_step = (cnt_reg == CW'(W - 1));

  // One modmul step per lane per cycle. r is stable for the whole SQR/MUL
  // phase, so reading it directly is the same as using an entry snapshot.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [W-1:0] a_op, x_op;
    logic [W:0]   n_ext, dbl, t1, sum, t2;

    always_comb begin
      a_op = b_reg[gi];
      x_op = r_reg[gi];
      if (state_reg == REDUCE) begin
        a_op = W'(1);
        x_op = base_reg[gi];
      end else if (state_reg == SQR) begin
        a_op = r_reg[gi];
      end
    end

    assign n_ext    = {1'b0, n_reg};
    assign dbl      = {acc_reg[gi], 1'b0};
    assign t1       = (dbl >= n_ext) ? dbl - n_ext : dbl;
    assign sum      = x_op[bidx] ? t1 + {1'b0, a_op} : t1;
    assign t2       = (sum >= n_ext) ? sum - n_ext : sum;
    assign prod[gi] = t2[W-1:0];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (modulus == '0) ? WRITE : REDUCE;
      REDUCE:  if (last_step) state_next = SQR;
      SQR:     if (last_step) state_next = MUL;
      MUL:     if (last_step) state_next = (k_reg == '0) ? WRITE : SQR;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      dst_reg   <= '0;
      base_reg  <= '0;
      expo_reg  <= '0;
      b_reg     <= '0;
      r_reg     <= '0;
      acc_reg   <= '0;
      n_reg     <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            dst_reg  <= dst;
            base_reg <= base;
            expo_reg <= expo;
            n_reg    <= modulus;
            err_reg  <= (modulus == '0);
            r_reg    <= {LANES{(modulus == W'(1)) ? W'(0) : W'(1)}};
            k_reg    <= CW'(W - 1);
            cnt_reg  <= '0;
            acc_reg  <= '0;
          end
        end
        REDUCE, SQR, MUL: begin
          cnt_reg <= last_step ? '0 : cnt_reg + 1'b1;
          acc_reg <= last_step ? '0 : prod;
          if (last_step) begin
            if (state_reg == REDUCE) b_reg <= prod;
            if (state_reg == SQR) r_reg <= prod;
            if (state_reg == MUL) begin
              // Product is always computed; the exponent bit only picks it.
              for (int i = 0; i < LANES; i++)
                if (expo_reg[i][k_reg]) r_reg[i] <= prod[i];
              if (k_reg != '0) k_reg <= k_reg - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign done = (state_reg == WRITE);
  assign err  = done && err_reg;
  assign we   = done && !err_reg;
  assign wa   = we ? dst_reg : '0;
  assign wd   = we ? r_reg : '0;
  assign busy = (state_reg == REDUCE) || (state_reg == SQR) || (state_reg == MUL) || we;

endmodule
